// File: rtl/parser_seg_collect.sv
// parser_seg_collect: forwards an ingress AXIS packet unchanged to the packet
// FIFO while capturing its first C_NUM_SEGS beats into one wide segment
// register (beat 0 in the MSBs) and extracting the 12-bit VLAN ID from
// bytes 14-15 of the first beat.
module parser_seg_collect #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_SEGS         = 8,
  parameter int C_VLANID_WIDTH     = 12
) (
  input  logic                                     axis_clk,
  input  logic                                     reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]           s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]            s_axis_tuser,
  input  logic                                     s_axis_tvalid,
  input  logic                                     s_axis_tlast,
  output logic                                     s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]             pkt_out_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]           pkt_out_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            pkt_out_tuser,
  output logic                                     pkt_out_tlast,
  output logic                                     pkt_out_wr_en,
  input  logic                                     pkt_out_full,
  output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]  seg_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            seg_tuser,
  output logic [3:0]                               seg_nbeats,
  output logic                                     seg_valid,
  input  logic                                     seg_ready,
  output logic [C_VLANID_WIDTH-1:0]                vlan_id,
  output logic                                     vlan_valid,
  input  logic                                     vlan_full
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
  localparam int VW = C_VLANID_WIDTH;
  localparam logic [3:0] LAST_SLOT = 4'(C_NUM_SEGS - 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       seg_done;
  logic [3:0] beat_cnt;

  // Every beat goes to the packet FIFO untouched, written in the accept cycle.
  assign pkt_out_tdata = s_axis_tdata;
  assign pkt_out_tkeep = s_axis_tkeep;
  assign pkt_out_tuser = s_axis_tuser;
  assign pkt_out_tlast = s_axis_tlast;
  assign pkt_out_wr_en = accept;

  // Ready/accept, next state, and the "segment complete" strobe. A packet may
  // only start once the VLAN FIFO has room and the single segment buffer is
  // free (or draining this very cycle); later beats only need packet FIFO room.
  always_comb begin
    s_axis_tready = 1'b0;
    accept        = 1'b0;
    seg_done      = 1'b0;
    state_nxt     = state;
    case (state)
      IDLE:    s_axis_tready = ~pkt_out_full & ~vlan_full & (~seg_valid | seg_ready);
      default: s_axis_tready = ~pkt_out_full;
    endcase
    if (reset) s_axis_tready = 1'b0;
    accept = s_axis_tvalid & s_axis_tready;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_axis_tlast) begin
            seg_done = 1'b1;
          end else if (C_NUM_SEGS == 1) begin
            seg_done  = 1'b1;
            state_nxt = BODY;
          end else begin
            state_nxt = HDR;
          end
        end
      end
      HDR: begin
        if (accept) begin
          if (s_axis_tlast) begin
            seg_done  = 1'b1;
            state_nxt = IDLE;
          end else if (beat_cnt == LAST_SLOT) begin
            seg_done  = 1'b1;
            state_nxt = BODY;
          end
        end
      end
      BODY: begin
        if (accept && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Segment capture, segment handshake and VLAN extraction. The segment is
  // written in place: a new first beat is only accepted when the previous
  // segment is gone, so clearing the whole register then is safe.
  always_ff @(posedge axis_clk or posedge reset) begin
    if (reset) begin
      beat_cnt   <= '0;
      seg_tdata  <= '0;
      seg_tuser  <= '0;
      seg_nbeats <= '0;
      seg_valid  <= 1'b0;
      vlan_id    <= '0;
      vlan_valid <= 1'b0;
    end else begin
      vlan_valid <= 1'b0;
      if (seg_valid && seg_ready) seg_valid <= 1'b0;
      if (seg_done)               seg_valid <= 1'b1;
      if (accept && state == IDLE) begin
        seg_tdata                <= '0;
        seg_tdata[SW-1 -: DW]    <= s_axis_tdata;
        seg_tuser                <= s_axis_tuser;
        seg_nbeats               <= 4'd1;
        beat_cnt                 <= 4'd1;
        vlan_id                  <= VW'({s_axis_tdata[115:112], s_axis_tdata[127:120]});
        vlan_valid               <= 1'b1;
      end else if (accept && state == HDR) begin
        for (int i = 1; i < C_NUM_SEGS; i++) begin
          if (beat_cnt == 4'(i)) seg_tdata[(C_NUM_SEGS-1-i)*DW +: DW] <= s_axis_tdata;
        end
        beat_cnt   <= beat_cnt + 4'd1;
        seg_nbeats <= beat_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_parser_seg_collect.sv
// Directed testbench for parser_seg_collect: hand-built packets, expected
// beats/segments/VLAN IDs generated from the packet pattern functions.
module tb_parser_seg_collect;

  localparam int DW = 256;
  localparam int TW = 128;
  localparam int NS = 8;
  localparam int SW = NS * DW;

  logic              axis_clk;
  logic              reset;
  logic [DW-1:0]     s_axis_tdata;
  logic [DW/8-1:0]   s_axis_tkeep;
  logic [TW-1:0]     s_axis_tuser;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [DW-1:0]     pkt_out_tdata;
  logic [DW/8-1:0]   pkt_out_tkeep;
  logic [TW-1:0]     pkt_out_tuser;
  logic              pkt_out_tlast;
  logic              pkt_out_wr_en;
  logic              pkt_out_full;
  logic [SW-1:0]     seg_tdata;
  logic [TW-1:0]     seg_tuser;
  logic [3:0]        seg_nbeats;
  logic              seg_valid;
  logic              seg_ready;
  logic [11:0]       vlan_id;
  logic              vlan_valid;
  logic              vlan_full;

  parser_seg_collect #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TW), .C_NUM_SEGS(NS), .C_VLANID_WIDTH(12)
  ) dut (
    .axis_clk(axis_clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .pkt_out_tdata(pkt_out_tdata), .pkt_out_tkeep(pkt_out_tkeep), .pkt_out_tuser(pkt_out_tuser),
    .pkt_out_tlast(pkt_out_tlast), .pkt_out_wr_en(pkt_out_wr_en), .pkt_out_full(pkt_out_full),
    .seg_tdata(seg_tdata), .seg_tuser(seg_tuser), .seg_nbeats(seg_nbeats),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .vlan_id(vlan_id), .vlan_valid(vlan_valid), .vlan_full(vlan_full)
  );

  typedef struct packed { logic [DW-1:0] d; logic l; } wr_t;
  typedef struct packed { logic [SW-1:0] d; logic [TW-1:0] u; logic [3:0] n; logic [31:0] c; } seg_t;

  wr_t         wr_q[$];
  int          wrc_q[$];
  logic [11:0] vlan_q[$];
  seg_t        seg_q[$];
  logic        prev_sv = 1'b0;
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Observe the DUT on the falling edge, away from the active edge.
  always @(negedge axis_clk) begin
    if (pkt_out_wr_en) begin
      wr_q.push_back('{d: pkt_out_tdata, l: pkt_out_tlast});
      wrc_q.push_back(cyc);
    end
    if (vlan_valid) vlan_q.push_back(vlan_id);
    if (seg_valid && !prev_sv) seg_q.push_back('{d: seg_tdata, u: seg_tuser, n: seg_nbeats, c: cyc});
    prev_sv = seg_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_beat(input int p, input int i, input logic [15:0] tci);
    logic [DW-1:0] d;
    d = {8{p[7:0], i[7:0], 8'hC3, 8'h3C}};
    if (i == 0) begin
      d[119:112] = tci[15:8];
      d[127:120] = tci[7:0];
    end
    return d;
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int p, input int n, input logic [15:0] tci);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < NS && i < n; i++) s[(NS-1-i)*DW +: DW] = mk_beat(p, i, tci);
    return s;
  endfunction

  function automatic logic [DW-1:0] slot(input logic [SW-1:0] s, input int i);
    return s[(NS-1-i)*DW +: DW];
  endfunction

  task automatic clear_q();
    wr_q.delete(); wrc_q.delete(); vlan_q.delete(); seg_q.delete();
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic stall);
    logic acc;
    int   waited;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    acc = 1'b0; waited = 0;
    while (!acc) begin
      if (stall) pkt_out_full = cyc[0];
      #1;
      acc = s_axis_tready;
      @(posedge axis_clk); #2;
      waited++;
      if (!acc && waited > 200) begin
        nchk++; nerr++;
        $display("FAIL beat_timeout: got no accept after %0d cycles, required accept", waited);
        break;
      end
    end
    s_axis_tvalid = 1'b0; pkt_out_full = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int n, input logic [15:0] tci,
                          input logic [TW-1:0] tu, input logic stall);
    s_axis_tuser = tu;
    for (int i = 0; i < n; i++) drive_beat(mk_beat(p, i, tci), (i == n - 1), stall);
  endtask

  task automatic settle();
    repeat (3) @(posedge axis_clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge axis_clk);
    #2;
    s_axis_tvalid = 1'b1; s_axis_tdata = mk_beat(0, 0, 16'h0FFF);
    #1;
    nchk++; if (s_axis_tready !== 1'b0) begin nerr++; $display("FAIL rst_tready: got %b required 0", s_axis_tready); end
    nchk++; if (pkt_out_wr_en !== 1'b0) begin nerr++; $display("FAIL rst_wr_en: got %b required 0", pkt_out_wr_en); end
    nchk++; if (seg_valid !== 1'b0) begin nerr++; $display("FAIL rst_seg_valid: got %b required 0", seg_valid); end
    nchk++; if (seg_tdata !== '0) begin nerr++; $display("FAIL rst_seg_tdata: got top %h required 0", seg_tdata[SW-1 -: DW]); end
    nchk++; if (seg_nbeats !== 4'd0 || seg_tuser !== '0) begin nerr++; $display("FAIL rst_seg_meta: got nbeats %0d tuser %h required 0", seg_nbeats, seg_tuser); end
    nchk++; if (vlan_valid !== 1'b0 || vlan_id !== 12'h000) begin nerr++; $display("FAIL rst_vlan: got valid %b id %h required 0/000", vlan_valid, vlan_id); end
    s_axis_tvalid = 1'b0;
    @(posedge axis_clk); #2;
    reset = 1'b0;
    repeat (2) @(posedge axis_clk);
    #2;
    clear_q();
  endtask

  task automatic test_long_pkt();
    seg_t sg;
    wr_t  ew;
    clear_q(); seg_ready = 1'b1;
    send_pkt(1, 10, 16'h0ABC, 128'hA1, 1'b0);
    settle();
    nchk++; if (wr_q.size() != 10) begin nerr++; $display("FAIL long_wr_count: got %0d required 10", wr_q.size()); end
    for (int i = 0; i < 10; i++) begin
      ew = {mk_beat(1, i, 16'h0ABC), (i == 9)};
      nchk++;
      if (i >= wr_q.size() || wr_q[i] !== ew) begin nerr++; $display("FAIL long_wr_beat%0d: got %h required %h", i, (i < wr_q.size()) ? wr_q[i].d : '0, ew.d); end
    end
    sg = (seg_q.size() > 0) ? seg_q[0] : '0;
    nchk++; if (seg_q.size() != 1) begin nerr++; $display("FAIL long_seg_count: got %0d required 1", seg_q.size()); end
    for (int i = 0; i < NS; i++) begin
      nchk++;
      if (slot(sg.d, i) !== slot(exp_seg(1, 10, 16'h0ABC), i)) begin nerr++; $display("FAIL long_slot%0d: got %h required %h", i, slot(sg.d, i), slot(exp_seg(1, 10, 16'h0ABC), i)); end
    end
    nchk++; if (sg.n !== 4'd8) begin nerr++; $display("FAIL long_nbeats: got %0d required 8", sg.n); end
    nchk++; if (sg.u !== 128'hA1) begin nerr++; $display("FAIL long_tuser: got %h required a1", sg.u); end
    nchk++; if (wrc_q.size() < 8 || sg.c != wrc_q[7] + 1) begin nerr++; $display("FAIL long_seg_timing: got cycle %0d required one after beat 8 write", sg.c); end
    nchk++; if (vlan_q.size() != 1) begin nerr++; $display("FAIL long_vlan_pulses: got %0d required 1", vlan_q.size()); end
    nchk++; if (vlan_q.size() < 1 || vlan_q[0] !== 12'hABC) begin nerr++; $display("FAIL long_vlan_id: got %h required abc", (vlan_q.size() > 0) ? vlan_q[0] : 12'h0); end
  endtask

  task automatic test_short_pkt();
    seg_t sg;
    clear_q(); seg_ready = 1'b1;
    send_pkt(2, 3, 16'h0123, 128'hB2, 1'b0);
    settle();
    sg = (seg_q.size() > 0) ? seg_q[0] : '0;
    nchk++; if (wr_q.size() != 3) begin nerr++; $display("FAIL short_wr_count: got %0d required 3", wr_q.size()); end
    nchk++; if (sg.n !== 4'd3) begin nerr++; $display("FAIL short_nbeats: got %0d required 3", sg.n); end
    for (int i = 0; i < NS; i++) begin
      nchk++;
      if (slot(sg.d, i) !== slot(exp_seg(2, 3, 16'h0123), i)) begin nerr++; $display("FAIL short_slot%0d: got %h required %h", i, slot(sg.d, i), slot(exp_seg(2, 3, 16'h0123), i)); end
    end
    nchk++; if (wrc_q.size() < 3 || sg.c != wrc_q[2] + 1) begin nerr++; $display("FAIL short_seg_timing: got cycle %0d required one after beat 3 write", sg.c); end
    nchk++; if (vlan_q.size() != 1 || vlan_q[0] !== 12'h123) begin nerr++; $display("FAIL short_vlan: got %0d pulses required 1 with id 123", vlan_q.size()); end
    // Only IDLE gates ready on vlan_full, so this shows the FSM is back in IDLE.
    vlan_full = 1'b1; #1;
    nchk++; if (s_axis_tready !== 1'b0) begin nerr++; $display("FAIL short_idle: got tready %b required 0", s_axis_tready); end
    vlan_full = 1'b0; #1;
    nchk++; if (s_axis_tready !== 1'b1) begin nerr++; $display("FAIL short_idle_ready: got tready %b required 1", s_axis_tready); end
    @(posedge axis_clk); #2;
  endtask

  task automatic test_back_to_back();
    int leaks;
    seg_t sa, sb;
    clear_q(); seg_ready = 1'b0;
    send_pkt(3, 3, 16'h0333, 128'hC3, 1'b0);
    s_axis_tuser = 128'hC4; s_axis_tdata = mk_beat(4, 0, 16'h0444); s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    leaks = 0;
    for (int k = 0; k < 20; k++) begin
      #1; if (s_axis_tready) leaks++;
      @(posedge axis_clk); #2;
    end
    nchk++; if (leaks != 0) begin nerr++; $display("FAIL b2b_blocked: got %0d ready cycles required 0", leaks); end
    nchk++; if (wr_q.size() != 3) begin nerr++; $display("FAIL b2b_no_write: got %0d writes required 3", wr_q.size()); end
    nchk++; if (seg_valid !== 1'b1 || seg_tdata !== exp_seg(3, 3, 16'h0333)) begin nerr++; $display("FAIL b2b_hold: got valid %b top %h required 1 %h", seg_valid, seg_tdata[SW-1 -: DW], mk_beat(3, 0, 16'h0333)); end
    seg_ready = 1'b1; #1;
    nchk++; if (s_axis_tready !== 1'b1) begin nerr++; $display("FAIL b2b_drain_ready: got %b required 1", s_axis_tready); end
    @(posedge axis_clk); #2;
    s_axis_tvalid = 1'b0; #1;
    nchk++; if (wr_q.size() != 4 || seg_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drain_accept: got writes %0d valid %b required 4 0", wr_q.size(), seg_valid); end
    drive_beat(mk_beat(4, 1, 16'h0444), 1'b1, 1'b0);
    settle();
    sa = (seg_q.size() > 0) ? seg_q[0] : '0;
    sb = (seg_q.size() > 1) ? seg_q[1] : '0;
    nchk++; if (sa.d !== exp_seg(3, 3, 16'h0333) || sa.n !== 4'd3) begin nerr++; $display("FAIL b2b_seg_a: got nbeats %0d top %h required 3 %h", sa.n, sa.d[SW-1 -: DW], mk_beat(3, 0, 16'h0333)); end
    nchk++; if (sb.d !== exp_seg(4, 2, 16'h0444) || sb.n !== 4'd2 || sb.u !== 128'hC4) begin nerr++; $display("FAIL b2b_seg_b: got nbeats %0d top %h required 2 %h", sb.n, sb.d[SW-1 -: DW], mk_beat(4, 0, 16'h0444)); end
    nchk++; if (vlan_q.size() != 2 || vlan_q[0] !== 12'h333 || vlan_q[1] !== 12'h444) begin nerr++; $display("FAIL b2b_vlan: got %0d pulses required 2 (333, 444)", vlan_q.size()); end
  endtask

  task automatic test_fifo_stall();
    seg_t sg;
    wr_t  ew;
    clear_q(); seg_ready = 1'b1;
    send_pkt(8, 12, 16'h0FED, 128'hE8, 1'b1);
    settle();
    nchk++; if (wr_q.size() != 12) begin nerr++; $display("FAIL stall_wr_count: got %0d required 12", wr_q.size()); end
    for (int i = 0; i < 12; i++) begin
      ew = {mk_beat(8, i, 16'h0FED), (i == 11)};
      nchk++;
      if (i >= wr_q.size() || wr_q[i] !== ew) begin nerr++; $display("FAIL stall_wr_beat%0d: got %h required %h", i, (i < wr_q.size()) ? wr_q[i].d : '0, ew.d); end
    end
    sg = (seg_q.size() > 0) ? seg_q[0] : '0;
    for (int i = 0; i < NS; i++) begin
      nchk++;
      if (slot(sg.d, i) !== mk_beat(8, i, 16'h0FED)) begin nerr++; $display("FAIL stall_slot%0d: got %h required %h", i, slot(sg.d, i), mk_beat(8, i, 16'h0FED)); end
    end
    nchk++; if (sg.n !== 4'd8 || vlan_q.size() != 1 || vlan_q[0] !== 12'hFED) begin nerr++; $display("FAIL stall_meta: got nbeats %0d vlan pulses %0d required 8 1 (fed)", sg.n, vlan_q.size()); end
  endtask

  task automatic test_vlan_full();
    int leaks;
    seg_t sg;
    clear_q(); seg_ready = 1'b1; vlan_full = 1'b1;
    s_axis_tuser = 128'hF5; s_axis_tdata = mk_beat(5, 0, 16'hF00D); s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    leaks = 0;
    for (int k = 0; k < 5; k++) begin
      #1; if (s_axis_tready) leaks++;
      @(posedge axis_clk); #2;
    end
    nchk++; if (leaks != 0 || wr_q.size() != 0) begin nerr++; $display("FAIL vfull_block: got ready %0d writes %0d required 0 0", leaks, wr_q.size()); end
    vlan_full = 1'b0;
    send_pkt(5, 2, 16'hF00D, 128'hF5, 1'b0);
    settle();
    sg = (seg_q.size() > 0) ? seg_q[0] : '0;
    nchk++; if (wr_q.size() != 2) begin nerr++; $display("FAIL vfull_wr_count: got %0d required 2", wr_q.size()); end
    nchk++; if (sg.d !== exp_seg(5, 2, 16'hF00D) || sg.n !== 4'd2) begin nerr++; $display("FAIL vfull_seg: got nbeats %0d top %h required 2 %h", sg.n, sg.d[SW-1 -: DW], mk_beat(5, 0, 16'hF00D)); end
    nchk++; if (vlan_q.size() != 1 || vlan_q[0] !== 12'h00D) begin nerr++; $display("FAIL vfull_vlan: got %0d pulses required 1 with id 00d", vlan_q.size()); end
  endtask

  task automatic test_mid_reset();
    seg_t sg;
    clear_q(); seg_ready = 1'b1;
    s_axis_tuser = 128'h66;
    for (int i = 0; i < 5; i++) drive_beat(mk_beat(6, i, 16'h0777), 1'b0, 1'b0);
    s_axis_tdata = mk_beat(6, 5, 16'h0777); s_axis_tvalid = 1'b1; reset = 1'b1;
    #1;
    nchk++; if (s_axis_tready !== 1'b0 || pkt_out_wr_en !== 1'b0) begin nerr++; $display("FAIL mrst_ready: got tready %b wr_en %b required 0 0", s_axis_tready, pkt_out_wr_en); end
    nchk++; if (seg_valid !== 1'b0 || seg_tdata !== '0 || seg_nbeats !== 4'd0 || seg_tuser !== '0) begin nerr++; $display("FAIL mrst_seg: got valid %b nbeats %0d top %h required 0 0 0", seg_valid, seg_nbeats, seg_tdata[SW-1 -: DW]); end
    nchk++; if (vlan_valid !== 1'b0 || vlan_id !== 12'h000) begin nerr++; $display("FAIL mrst_vlan: got valid %b id %h required 0 000", vlan_valid, vlan_id); end
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge axis_clk);
    #2;
    reset = 1'b0;
    @(posedge axis_clk); #2;
    clear_q();
    send_pkt(7, 4, 16'h0321, 128'h77, 1'b0);
    settle();
    sg = (seg_q.size() > 0) ? seg_q[0] : '0;
    nchk++; if (wr_q.size() != 4) begin nerr++; $display("FAIL mrst_wr_count: got %0d required 4", wr_q.size()); end
    for (int i = 0; i < NS; i++) begin
      nchk++;
      if (slot(sg.d, i) !== slot(exp_seg(7, 4, 16'h0321), i)) begin nerr++; $display("FAIL mrst_slot%0d: got %h required %h", i, slot(sg.d, i), slot(exp_seg(7, 4, 16'h0321), i)); end
    end
    nchk++; if (sg.n !== 4'd4 || sg.u !== 128'h77) begin nerr++; $display("FAIL mrst_meta: got nbeats %0d tuser %h required 4 77", sg.n, sg.u); end
    nchk++; if (vlan_q.size() != 1 || vlan_q[0] !== 12'h321) begin nerr++; $display("FAIL mrst_vlan_id: got %0d pulses required 1 with id 321", vlan_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    pkt_out_full = 1'b0; seg_ready = 1'b1; vlan_full = 1'b0;
    test_reset();
    test_long_pkt();
    test_short_pkt();
    test_back_to_back();
    test_fifo_stall();
    test_vlan_full();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
